// File: rtl/m_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : m_mem_arbiter
// Purpose  : Two-requester arbiter in front of one single-port word memory
//            (asynchronous read, synchronous write). Port 0 is instruction
//            fetch and port 1 is data load/store, so one array can hold both
//            code and data for a multi-cycle processor.
//            Arbitration is round-robin with bounded burst ownership. Read
//            data returns registered, one cycle after the grant.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW         word-address width
//   DW         data width
//   BURST_MAX  max consecutive grants to one owner while the other requests
//              (legal 1..15)
// Ports
//   w_clk, w_rst               clock (posedge), async active-high reset
//   w_req/addr/we/din{0,1}     requester side; held stable until granted
//   w_gnt{0,1}                 grant (combinational)
//   w_vld{0,1}, w_dout{0,1}    registered read result (vld is a 1-cycle pulse)
//   w_maddr, w_mwe, w_mdin     memory address / write enable / write data
//   w_mdout                    memory read data (combinational)
// Optional build macro
//   ARB_STATS_EN   adds 16-bit wrapping counters w_ngnt0, w_ngnt1, w_nconf
// ============================================================================
module m_mem_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          w_req0,
    input  logic [AW-1:0] w_addr0,
    input  logic          w_we0,
    input  logic [DW-1:0] w_din0,
    output logic          w_gnt0,
    output logic          w_vld0,
    output logic [DW-1:0] w_dout0,
    input  logic          w_req1,
    input  logic [AW-1:0] w_addr1,
    input  logic          w_we1,
    input  logic [DW-1:0] w_din1,
    output logic          w_gnt1,
    output logic          w_vld1,
    output logic [DW-1:0] w_dout1,
    output logic [AW-1:0] w_maddr,
    output logic          w_mwe,
    output logic [DW-1:0] w_mdin,
    input  logic [DW-1:0] w_mdout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   w_ngnt0,
    output logic [15:0]   w_ngnt1,
    output logic [15:0]   w_nconf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] c_burst_max = 4'(BURST_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_last;
    logic        w_last_nxt;
    logic        w_pick0;
    logic        w_pick1;
    logic        w_both;

    assign w_both = w_req0 & w_req1;

    // Grant decision. The owner keeps the memory during a conflict until its
    // burst budget runs out; otherwise the port that did not win last goes.
    always_comb begin
        w_pick0 = 1'b0;
        w_pick1 = 1'b0;
        if (w_req0 && !w_req1) begin
            w_pick0 = 1'b1;
        end else if (w_req1 && !w_req0) begin
            w_pick1 = 1'b1;
        end else if (w_both) begin
            if (r_state == OWN0 && r_cnt < c_burst_max) begin
                w_pick0 = 1'b1;
            end else if (r_state == OWN1 && r_cnt < c_burst_max) begin
                w_pick1 = 1'b1;
            end else if (r_last) begin
                w_pick0 = 1'b1;
            end else begin
                w_pick1 = 1'b1;
            end
        end
    end

    // Reset masks the grants so nothing reaches the memory while held.
    assign w_gnt0 = w_pick0 & ~w_rst;
    assign w_gnt1 = w_pick1 & ~w_rst;

    // Next-state: r_cnt counts consecutive grants to the same owner and
    // saturates at the budget, so a lone owner can run on indefinitely.
    always_comb begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
        w_last_nxt  = r_last;
        if (w_gnt0) begin
            w_state_nxt = OWN0;
            w_last_nxt  = 1'b0;
            if (r_state == OWN0) begin
                w_cnt_nxt = (r_cnt >= c_burst_max) ? c_burst_max : r_cnt + 4'd1;
            end else begin
                w_cnt_nxt = 4'd1;
            end
        end else if (w_gnt1) begin
            w_state_nxt = OWN1;
            w_last_nxt  = 1'b1;
            if (r_state == OWN1) begin
                w_cnt_nxt = (r_cnt >= c_burst_max) ? c_burst_max : r_cnt + 4'd1;
            end else begin
                w_cnt_nxt = 4'd1;
            end
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Memory mux; address defaults to port 0 when idle.
    assign w_maddr = w_gnt1 ? w_addr1 : w_addr0;
    assign w_mwe   = (w_gnt0 & w_we0) | (w_gnt1 & w_we1);
    assign w_mdin  = w_gnt0 ? w_din0 : (w_gnt1 ? w_din1 : '0);

    // Read return path: capture at the edge that ends the grant cycle.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_vld0  <= 1'b0;
            w_dout0 <= '0;
            w_vld1  <= 1'b0;
            w_dout1 <= '0;
        end else begin
            w_vld0 <= w_gnt0 & ~w_we0;
            w_vld1 <= w_gnt1 & ~w_we1;
            if (w_gnt0 && !w_we0) begin
                w_dout0 <= w_mdout;
            end
            if (w_gnt1 && !w_we1) begin
                w_dout1 <= w_mdout;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_ngnt0;
    logic [15:0] r_ngnt1;
    logic [15:0] r_nconf;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_ngnt0 <= 16'd0;
            r_ngnt1 <= 16'd0;
            r_nconf <= 16'd0;
        end else begin
            if (w_gnt0) begin
                r_ngnt0 <= r_ngnt0 + 16'd1;
            end
            if (w_gnt1) begin
                r_ngnt1 <= r_ngnt1 + 16'd1;
            end
            if (w_both) begin
                r_nconf <= r_nconf + 16'd1;
            end
        end
    end

    assign w_ngnt0 = r_ngnt0;
    assign w_ngnt1 = r_ngnt1;
    assign w_nconf = r_nconf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_mem_arbiter
// Purpose  : Self-checking bench for m_mem_arbiter with a behavioural word
//            memory and per-port expected-read-data queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          w_clk;
    logic          w_rst;
    logic          w_req0, w_we0, w_req1, w_we1;
    logic [AW-1:0] w_addr0, w_addr1;
    logic [DW-1:0] w_din0, w_din1;
    logic          w_gnt0, w_gnt1, w_vld0, w_vld1;
    logic [DW-1:0] w_dout0, w_dout1;
    logic [AW-1:0] w_maddr;
    logic          w_mwe;
    logic [DW-1:0] w_mdin, w_mdout;
`ifdef ARB_STATS_EN
    logic [15:0]   w_ngnt0, w_ngnt1, w_nconf;
`endif

    int n_cmp;
    int n_bad;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    m_mem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(4)) dut (
        .w_clk  (w_clk),
        .w_rst  (w_rst),
        .w_req0 (w_req0),
        .w_addr0(w_addr0),
        .w_we0  (w_we0),
        .w_din0 (w_din0),
        .w_gnt0 (w_gnt0),
        .w_vld0 (w_vld0),
        .w_dout0(w_dout0),
        .w_req1 (w_req1),
        .w_addr1(w_addr1),
        .w_we1  (w_we1),
        .w_din1 (w_din1),
        .w_gnt1 (w_gnt1),
        .w_vld1 (w_vld1),
        .w_dout1(w_dout1),
        .w_maddr(w_maddr),
        .w_mwe  (w_mwe),
        .w_mdin (w_mdin),
        .w_mdout(w_mdout)
`ifdef ARB_STATS_EN
        ,
        .w_ngnt0(w_ngnt0),
        .w_ngnt1(w_ngnt1),
        .w_nconf(w_nconf)
`endif
    );

    initial w_clk = 1'b0;
    always #10 w_clk = ~w_clk;

    // Behavioural memory: unwritten words read back a fixed pattern.
    function automatic logic [DW-1:0] f_init(input logic [AW-1:0] a);
        return (a == 12'h003) ? 32'h00851020 : {20'hA5A5A, a};
    endfunction

    logic [DW-1:0] r_mem     [0:(1<<AW)-1];
    logic          r_written [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            r_mem[i]     = '0;
            r_written[i] = 1'b0;
        end
    end

    always @(posedge w_clk) begin
        if (w_mwe) begin
            r_mem[w_maddr]     <= w_mdin;
            r_written[w_maddr] <= 1'b1;
        end
    end

    assign w_mdout = r_written[w_maddr] ? r_mem[w_maddr] : f_init(w_maddr);

    task automatic pulse_reset();
        @(negedge w_clk);
        w_rst = 1'b1;
        w_req0 = 1'b0;
        w_req1 = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        w_rst = 1'b1;
        w_req0 = 1'b1; w_we0 = 1'b1; w_addr0 = 12'h005; w_din0 = 32'h11111111;
        w_req1 = 1'b1; w_we1 = 1'b1; w_addr1 = 12'h006; w_din1 = 32'h22222222;
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        #1;
        got = {w_gnt0, w_gnt1, w_mwe, w_vld0, w_vld1, r_written[5], r_written[6]};
        n_cmp++;
        if (got !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: gnt0,gnt1,mwe,vld0,vld1,wr5,wr6 = %b required 0000000", got);
        end
        n_cmp++;
        if (w_dout0 !== 32'h0 || w_dout1 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_dout: dout0=%h dout1=%h required 0/0", w_dout0, w_dout1);
        end
        w_req0 = 1'b0; w_req1 = 1'b0; w_we0 = 1'b0; w_we1 = 1'b0;
        w_rst = 1'b0;
    endtask

    task automatic test_solo_read();
        logic [DW-1:0] exp_d;
        @(negedge w_clk);
        w_req0 = 1'b1; w_addr0 = 12'h003; w_we0 = 1'b0;
        #1;
        n_cmp++;
        if (w_gnt0 !== 1'b1 || w_gnt1 !== 1'b0 || w_maddr !== 12'h003 || w_mwe !== 1'b0) begin
            n_bad++;
            $display("FAIL solo_grant: gnt0=%b gnt1=%b maddr=%h mwe=%b required 1 0 003 0",
                     w_gnt0, w_gnt1, w_maddr, w_mwe);
        end
        q0.push_back(32'h00851020);
        @(posedge w_clk);
        #1;
        w_req0 = 1'b0;
        n_cmp++;
        if (w_vld0 !== 1'b1 || q0.size() == 0) begin
            n_bad++;
            $display("FAIL solo_vld: vld0=%b required 1", w_vld0);
        end else begin
            exp_d = q0.pop_front();
            n_cmp++;
            if (w_dout0 !== exp_d) begin
                n_bad++;
                $display("FAIL solo_dout: dout0=%h required %h", w_dout0, exp_d);
            end
        end
        @(posedge w_clk);
        #1;
        n_cmp++;
        if (w_vld0 !== 1'b0 || w_dout0 !== 32'h00851020) begin
            n_bad++;
            $display("FAIL solo_hold: vld0=%b dout0=%h required 0 00851020", w_vld0, w_dout0);
        end
    endtask

    task automatic test_conflict();
        int k;
        logic [DW-1:0] exp_d;
        pulse_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge w_clk);
            w_req0 = 1'b1; w_addr0 = 12'h010; w_we0 = 1'b0;
            w_req1 = 1'b1; w_addr1 = 12'h020; w_we1 = 1'b0;
            k = (i / 4) % 2;
            #1;
            n_cmp++;
            if (w_gnt0 !== (k == 0) || w_gnt1 !== (k == 1)) begin
                n_bad++;
                $display("FAIL conflict_gnt[%0d]: gnt0=%b gnt1=%b required port %0d", i, w_gnt0, w_gnt1, k);
            end
            if (k == 0) q0.push_back(f_init(12'h010));
            else        q1.push_back(f_init(12'h020));
            @(posedge w_clk);
            #1;
            n_cmp++;
            if (w_vld0 !== (k == 0) || w_vld1 !== (k == 1)) begin
                n_bad++;
                $display("FAIL conflict_vld[%0d]: vld0=%b vld1=%b required port %0d", i, w_vld0, w_vld1, k);
            end
            if (w_vld0 === 1'b1 && q0.size() > 0) begin
                exp_d = q0.pop_front();
                n_cmp++;
                if (w_dout0 !== exp_d) begin
                    n_bad++;
                    $display("FAIL conflict_dout0[%0d]: dout0=%h required %h", i, w_dout0, exp_d);
                end
            end
            if (w_vld1 === 1'b1 && q1.size() > 0) begin
                exp_d = q1.pop_front();
                n_cmp++;
                if (w_dout1 !== exp_d) begin
                    n_bad++;
                    $display("FAIL conflict_dout1[%0d]: dout1=%h required %h", i, w_dout1, exp_d);
                end
            end
        end
        q0.delete();
        q1.delete();
        w_req0 = 1'b0; w_req1 = 1'b0;
    endtask

    task automatic test_saturate();
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge w_clk);
            w_req0 = 1'b1; w_addr0 = 12'h030; w_we0 = 1'b0; w_req1 = 1'b0;
            #1;
            n_cmp++;
            if (w_gnt0 !== 1'b1) begin
                n_bad++;
                $display("FAIL solo_run_gnt0[%0d]: gnt0=%b required 1", i, w_gnt0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge w_clk);
            w_req0 = 1'b1; w_req1 = 1'b1; w_addr1 = 12'h031; w_we1 = 1'b0;
            #1;
            n_cmp++;
            if (w_gnt0 !== 1'b0 || w_gnt1 !== 1'b1) begin
                n_bad++;
                $display("FAIL yield_gnt[%0d]: gnt0=%b gnt1=%b required 0 1", i, w_gnt0, w_gnt1);
            end
        end
        @(negedge w_clk);
        w_req0 = 1'b0; w_req1 = 1'b0;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp_d;
        @(negedge w_clk);
        w_req0 = 1'b0;
        w_req1 = 1'b1; w_we1 = 1'b1; w_addr1 = 12'h100; w_din1 = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (w_gnt1 !== 1'b1 || w_mwe !== 1'b1 || w_maddr !== 12'h100 || w_mdin !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL write_mux: gnt1=%b mwe=%b maddr=%h mdin=%h required 1 1 100 deadbeef",
                     w_gnt1, w_mwe, w_maddr, w_mdin);
        end
        @(posedge w_clk);
        #1;
        n_cmp++;
        if (w_vld1 !== 1'b0 || r_written[12'h100] !== 1'b1 || r_mem[12'h100] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL write_commit: vld1=%b mem=%h required 0 deadbeef", w_vld1, r_mem[12'h100]);
        end
        @(negedge w_clk);
        w_we1 = 1'b0;
        #1;
        n_cmp++;
        if (w_gnt1 !== 1'b1 || w_mwe !== 1'b0) begin
            n_bad++;
            $display("FAIL readback_gnt: gnt1=%b mwe=%b required 1 0", w_gnt1, w_mwe);
        end
        q1.push_back(32'hDEADBEEF);
        @(posedge w_clk);
        #1;
        w_req1 = 1'b0;
        n_cmp++;
        if (w_vld1 !== 1'b1 || q1.size() == 0) begin
            n_bad++;
            $display("FAIL readback_vld: vld1=%b required 1", w_vld1);
        end else begin
            exp_d = q1.pop_front();
            n_cmp++;
            if (w_dout1 !== exp_d) begin
                n_bad++;
                $display("FAIL readback_dout: dout1=%h required %h", w_dout1, exp_d);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] exp_d;
        @(posedge w_clk);
        #1;
        w_req0 = 1'b1; w_addr0 = 12'h003; w_we0 = 1'b0; w_req1 = 1'b0;
        #1;
        n_cmp++;
        if (w_gnt0 !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre_gnt: gnt0=%b required 1", w_gnt0);
        end
        @(negedge w_clk);
        w_rst = 1'b1;
        #1;
        n_cmp++;
        if (w_gnt0 !== 1'b0 || w_mwe !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_gate: gnt0=%b mwe=%b required 0 0", w_gnt0, w_mwe);
        end
        @(posedge w_clk);
        #1;
        n_cmp++;
        if (w_vld0 !== 1'b0 || w_dout0 !== 32'h0) begin
            n_bad++;
            $display("FAIL midrst_drop: vld0=%b dout0=%h required 0 0", w_vld0, w_dout0);
        end
        @(negedge w_clk);
        w_rst = 1'b0;
        w_req0 = 1'b0;
        w_req1 = 1'b1; w_we1 = 1'b0; w_addr1 = 12'h040;
        #1;
        n_cmp++;
        if (w_gnt1 !== 1'b1 || w_gnt0 !== 1'b0 || w_maddr !== 12'h040) begin
            n_bad++;
            $display("FAIL midrst_after: gnt1=%b gnt0=%b maddr=%h required 1 0 040", w_gnt1, w_gnt0, w_maddr);
        end
        q1.push_back(f_init(12'h040));
        @(posedge w_clk);
        #1;
        w_req1 = 1'b0;
        n_cmp++;
        if (w_vld1 !== 1'b1 || q1.size() == 0) begin
            n_bad++;
            $display("FAIL midrst_vld1: vld1=%b required 1", w_vld1);
        end else begin
            exp_d = q1.pop_front();
            n_cmp++;
            if (w_dout1 !== exp_d) begin
                n_bad++;
                $display("FAIL midrst_dout1: dout1=%h required %h", w_dout1, exp_d);
            end
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge w_clk);
            w_req0 = 1'b1; w_we0 = 1'b0; w_req1 = 1'b1; w_we1 = 1'b0;
        end
        @(negedge w_clk);
        w_req0 = 1'b0; w_req1 = 1'b0;
        #1;
        n_cmp++;
        if (w_nconf !== 16'd10) begin
            n_bad++;
            $display("FAIL stats_nconf: nconf=%0d required 10", w_nconf);
        end
        n_cmp++;
        if (32'(w_ngnt0) + 32'(w_ngnt1) !== 32'd10) begin
            n_bad++;
            $display("FAIL stats_ngnt: ngnt0+ngnt1=%0d required 10", 32'(w_ngnt0) + 32'(w_ngnt1));
        end
        w_req0 = 1'b1; w_req1 = 1'b1;
        repeat (65526) @(negedge w_clk);
        w_req0 = 1'b0; w_req1 = 1'b0;
        #1;
        n_cmp++;
        if (w_nconf !== 16'd0) begin
            n_bad++;
            $display("FAIL stats_wrap: nconf=%0d required 0", w_nconf);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        w_rst = 1'b1;
        w_req0 = 1'b0; w_we0 = 1'b0; w_addr0 = '0; w_din0 = '0;
        w_req1 = 1'b0; w_we1 = 1'b0; w_addr1 = '0; w_din1 = '0;
        test_reset();
        test_solo_read();
        test_conflict();
        test_saturate();
        test_write_read();
        test_reset_mid_read();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        repeat (2) @(posedge w_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
